ram1_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 30 +++
 rtl/ram1_bus_io.sv | 47 ++++
 rtl/ram1_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram1_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared types and constants for the RAM1 access path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int WORD_W         = 16;
    localparam int RAM_ADDR_W_DEF = 18;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/ram1_bus_io.sv
// ============================================================================
//  Module   : ram1_bus_io
//  Brief    : ram1Data tristate driver and per-requester read capture registers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram1_bus_io
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drv_n,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_load_if,
    input  logic              i_load_mem,
    inout  wire  [WORD_W-1:0] io_data,
    output logic [WORD_W-1:0] o_if_rdata,
    output logic [WORD_W-1:0] o_mem_rdata
);

    logic [WORD_W-1:0] r_if_rdata;
    logic [WORD_W-1:0] r_mem_rdata;

    // Drive enable is a registered strobe, so the bus never glitches out.
    assign io_data = i_drv_n ? {WORD_W{1'bz}} : i_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (i_load_if) begin
                r_if_rdata <= io_data;
            end
            if (i_load_mem) begin
                r_mem_rdata <= io_data;
            end
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_mem_rdata = r_mem_rdata;

endmodule

`default_nettype wire

// File: rtl/ram1_arbiter.sv
// ============================================================================
//  Module   : ram1_arbiter
//  Brief    : Arbitrates fetch/data access to RAM1 and sequences SRAM strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram1_arbiter
    import cpu_pkg::*;
#(
    parameter int READ_WAIT  = 1,
    parameter int WE_CYCLES  = 1,
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  if_req,
    input  logic [WORD_W-1:0]     if_addr,
    output logic [WORD_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [WORD_W-1:0]     mem_addr,
    input  logic [WORD_W-1:0]     mem_wdata,
    output logic [WORD_W-1:0]     mem_rdata,
    output logic                  mem_ack,
    output logic                  stall,
    output logic                  ram1OE,
    output logic                  ram1WE,
    output logic                  ram1EN,
    output logic [RAM_ADDR_W-1:0] ram1Addr,
    inout  wire  [WORD_W-1:0]     ram1Data
);

    localparam int         c_PAD_W   = RAM_ADDR_W - WORD_W;
    localparam logic [7:0] c_RD_LAST = 8'(READ_WAIT - 1);
    localparam logic [7:0] c_WE_LAST = 8'(WE_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    owner_t                r_owner;
    owner_t                w_owner_nxt;
    logic [7:0]            r_cnt;
    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic [WORD_W-1:0]     r_wdata;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic                  r_en_n;
    logic                  r_drv_n;
    logic                  r_if_ack;
    logic                  r_mem_ack;

    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_grant_if;
    logic                  w_rd_last;
    logic [WORD_W-1:0]     w_addr_sel;
    logic                  w_oe_n_nxt;
    logic                  w_we_n_nxt;
    logic                  w_en_n_nxt;
    logic                  w_drv_n_nxt;
    logic                  w_if_ack_nxt;
    logic                  w_mem_ack_nxt;
    logic                  w_load_if;
    logic                  w_load_mem;

    // Fixed priority: write beats read beats fetch.
    assign w_grant_wr = mem_write;
    assign w_grant_rd = ~mem_write & mem_read;
    assign w_grant_if = ~mem_write & ~mem_read & if_req;
    assign w_addr_sel = (w_grant_wr | w_grant_rd) ? mem_addr : if_addr;
    assign w_rd_last  = (r_state == ST_RD) && (r_cnt == c_RD_LAST);
    assign w_load_if  = w_rd_last && (r_owner == OWN_INST);
    assign w_load_mem = w_rd_last && (r_owner == OWN_DATA);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = ST_WR_SETUP;
                    w_owner_nxt = OWN_DATA;
                end else if (w_grant_rd) begin
                    w_state_nxt = ST_RD;
                    w_owner_nxt = OWN_DATA;
                end else if (w_grant_if) begin
                    w_state_nxt = ST_RD;
                    w_owner_nxt = OWN_INST;
                end
            end
            ST_RD: begin
                if (w_rd_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (r_cnt == c_WE_LAST) begin
                    w_state_nxt = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWN_NONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase

        // Strobes are decoded from the next state and registered, so each
        // pin reflects the state it belongs to with no combinational path.
        w_en_n_nxt    = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
        w_oe_n_nxt    = (w_state_nxt != ST_RD);
        w_we_n_nxt    = (w_state_nxt != ST_WR_PULSE);
        w_drv_n_nxt   = !((w_state_nxt == ST_WR_SETUP) ||
                          (w_state_nxt == ST_WR_PULSE) ||
                          (w_state_nxt == ST_WR_HOLD));
        w_if_ack_nxt  = (w_state_nxt == ST_DONE) && (r_owner == OWN_INST);
        w_mem_ack_nxt = (w_state_nxt == ST_DONE) && (r_owner == OWN_DATA);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_NONE;
            r_cnt      <= 8'd0;
            r_ram_addr <= '0;
            r_wdata    <= '0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_en_n     <= 1'b1;
            r_drv_n    <= 1'b1;
            r_if_ack   <= 1'b0;
            r_mem_ack  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= (w_state_nxt == r_state) ? r_cnt + 8'd1 : 8'd0;
            r_oe_n    <= w_oe_n_nxt;
            r_we_n    <= w_we_n_nxt;
            r_en_n    <= w_en_n_nxt;
            r_drv_n   <= w_drv_n_nxt;
            r_if_ack  <= w_if_ack_nxt;
            r_mem_ack <= w_mem_ack_nxt;
            if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
                r_ram_addr <= {{c_PAD_W{1'b0}}, w_addr_sel};
                if (w_grant_wr) begin
                    r_wdata <= mem_wdata;
                end
            end
        end
    end

    ram1_bus_io u_bus_io (
        .clk         (CLK),
        .rst         (RST),
        .i_drv_n     (r_drv_n),
        .i_wdata     (r_wdata),
        .i_load_if   (w_load_if),
        .i_load_mem  (w_load_mem),
        .io_data     (ram1Data),
        .o_if_rdata  (if_rdata),
        .o_mem_rdata (mem_rdata)
    );

    assign ram1OE   = r_oe_n;
    assign ram1WE   = r_we_n;
    assign ram1EN   = r_en_n;
    assign ram1Addr = r_ram_addr;
    assign if_ack   = r_if_ack;
    assign mem_ack  = r_mem_ack;
    assign stall    = (if_req & ~r_if_ack) | ((mem_read | mem_write) & ~r_mem_ack);

endmodule

`default_nettype wire

// File: tb/tb_ram1_arbiter.sv
// ============================================================================
//  Module   : tb_ram1_arbiter
//  Brief    : Directed bench for ram1_arbiter, default and slow-timing instances.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram1_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        sel2 = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] mem_wdata = 16'h0;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // Request steering: sel2 routes stimulus to the slow-timing instance.
    logic a_if_req, a_mem_read, a_mem_write, b_if_req, b_mem_read, b_mem_write;
    assign a_if_req    = if_req    & ~sel2;
    assign a_mem_read  = mem_read  & ~sel2;
    assign a_mem_write = mem_write & ~sel2;
    assign b_if_req    = if_req    & sel2;
    assign b_mem_read  = mem_read  & sel2;
    assign b_mem_write = mem_write & sel2;

    logic [15:0] a_if_rdata, a_mem_rdata, b_if_rdata, b_mem_rdata;
    logic        a_if_ack, a_mem_ack, a_stall, a_oe, a_we, a_en;
    logic        b_if_ack, b_mem_ack, b_stall, b_oe, b_we, b_en;
    logic [17:0] a_addr, b_addr;
    wire  [15:0] a_data, b_data;

    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];

    for (genvar i = 0; i < 16; i++) begin : g_pd
        pulldown (a_data[i]);
        pulldown (b_data[i]);
    end

    // Async SRAM models: drive on OE read, commit a write cycle that ends outside reset.
    assign a_data = (!a_en && !a_oe && a_we) ? mem_a[a_addr[15:0]] : 16'hzzzz;
    assign b_data = (!b_en && !b_oe && b_we) ? mem_b[b_addr[15:0]] : 16'hzzzz;
    always @(posedge CLK) begin
        if (!RST && !a_en && !a_we) mem_a[a_addr[15:0]] <= a_data;
        if (!RST && !b_en && !b_we) mem_b[b_addr[15:0]] <= b_data;
    end

    ram1_arbiter dut (
        .CLK(CLK), .RST(RST),
        .if_req(a_if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
        .stall(a_stall), .ram1OE(a_oe), .ram1WE(a_we), .ram1EN(a_en),
        .ram1Addr(a_addr), .ram1Data(a_data)
    );

    ram1_arbiter #(.READ_WAIT(3), .WE_CYCLES(2), .RAM_ADDR_W(18)) dut2 (
        .CLK(CLK), .RST(RST),
        .if_req(b_if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .stall(b_stall), .ram1OE(b_oe), .ram1WE(b_we), .ram1EN(b_en),
        .ram1Addr(b_addr), .ram1Data(b_data)
    );

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({a_oe, a_we, a_en} !== 3'b111) begin
            n_err++; $display("FAIL reset_strobes got %b want 111", {a_oe, a_we, a_en});
        end
        n_vec++;
        if (a_data !== 16'h0000) begin
            n_err++; $display("FAIL reset_bus got %h want released", a_data);
        end
        n_vec++;
        if ({a_if_ack, a_mem_ack, a_stall} !== 3'b000) begin
            n_err++; $display("FAIL reset_ack_stall got %b want 000", {a_if_ack, a_mem_ack, a_stall});
        end
        n_vec++;
        if ({a_addr, a_if_rdata, a_mem_rdata} !== 50'h0) begin
            n_err++; $display("FAIL reset_regs got %h/%h/%h want 0", a_addr, a_if_rdata, a_mem_rdata);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_addr = 16'h0040; if_req = 1'b1;
        tick();
        n_vec++;
        if ({a_oe, a_en, a_if_ack, a_stall} !== 4'b0001 || a_addr !== 18'h00040) begin
            n_err++; $display("FAIL fetch_rd got oe%b en%b ack%b st%b addr %h want 0,0,0,1,00040",
                              a_oe, a_en, a_if_ack, a_stall, a_addr);
        end
        tick();
        n_vec++;
        if ({a_oe, a_if_ack, a_mem_ack, a_stall} !== 4'b1100 || a_if_rdata !== 16'h6801) begin
            n_err++; $display("FAIL fetch_done got oe%b ack%b mack%b st%b rdata %h want 1,1,0,0,6801",
                              a_oe, a_if_ack, a_mem_ack, a_stall, a_if_rdata);
        end
        if_req = 1'b0;
        tick();
        n_vec++;
        if (a_if_ack !== 1'b0) begin
            n_err++; $display("FAIL fetch_ack_one_cycle got %b want 0", a_if_ack);
        end
    endtask

    task automatic test_write();
        logic exp_we, exp_drv;
        mem_addr = 16'h8000; mem_wdata = 16'h1234; mem_write = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_we  = (c == 2) ? 1'b0 : 1'b1;
            exp_drv = (c <= 3);
            n_vec++;
            if (a_we !== exp_we || a_mem_ack !== (c == 4) || a_stall !== (c != 4)) begin
                n_err++; $display("FAIL write_c%0d got we%b ack%b st%b want we%b ack%b st%b",
                                  c, a_we, a_mem_ack, a_stall, exp_we, c == 4, c != 4);
            end
            n_vec++;
            if (exp_drv && (a_data !== 16'h1234 || a_addr !== 18'h08000 || a_en !== 1'b0)) begin
                n_err++; $display("FAIL write_bus_c%0d got %h @%h en%b want 1234 @08000 en0",
                                  c, a_data, a_addr, a_en);
            end else if (!exp_drv && a_data !== 16'h0000) begin
                n_err++; $display("FAIL write_release got %h want released", a_data);
            end
        end
        n_vec++;
        if (mem_a[16'h8000] !== 16'h1234 || a_mem_rdata !== 16'h0000) begin
            n_err++; $display("FAIL write_result got mem %h rdata %h want 1234 0000",
                              mem_a[16'h8000], a_mem_rdata);
        end
        mem_write = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        if_addr = 16'h0040; if_req = 1'b1; mem_addr = 16'h8000; mem_read = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_vec++;
            if (a_mem_ack !== (c == 2) || a_if_ack !== (c == 5) || a_stall !== (c != 5)) begin
                n_err++; $display("FAIL contend_c%0d got mack%b iack%b st%b want %b %b %b",
                                  c, a_mem_ack, a_if_ack, a_stall, c == 2, c == 5, c != 5);
            end
            if (c == 1 || c == 4) begin
                n_vec++;
                if (a_addr !== ((c == 1) ? 18'h08000 : 18'h00040)) begin
                    n_err++; $display("FAIL contend_addr_c%0d got %h", c, a_addr);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (a_mem_rdata !== 16'h1234) begin
                    n_err++; $display("FAIL contend_mrdata got %h want 1234", a_mem_rdata);
                end
                mem_read = 1'b0;
            end
            if (c == 5) begin
                n_vec++;
                if (a_if_rdata !== 16'h6801) begin
                    n_err++; $display("FAIL contend_irdata got %h want 6801", a_if_rdata);
                end
                if_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_drop_top_addr();
        mem_addr = 16'hFFFF; mem_read = 1'b1;
        tick();
        n_vec++;
        if (a_addr !== 18'h0FFFF || a_oe !== 1'b0) begin
            n_err++; $display("FAIL top_addr got %h oe%b want 0ffff oe0", a_addr, a_oe);
        end
        mem_read = 1'b0;
        tick();
        n_vec++;
        if (a_mem_ack !== 1'b1 || a_mem_rdata !== 16'h0F0F) begin
            n_err++; $display("FAIL drop_ack got ack%b rdata %h want 1 0f0f", a_mem_ack, a_mem_rdata);
        end
        tick();
        n_vec++;
        if (a_mem_ack !== 1'b0 || a_mem_rdata !== 16'h0F0F) begin
            n_err++; $display("FAIL drop_hold got ack%b rdata %h want 0 0f0f", a_mem_ack, a_mem_rdata);
        end
    endtask

    task automatic test_read_and_write();
        mem_addr = 16'h2000; mem_wdata = 16'hBEEF; mem_read = 1'b1; mem_write = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_vec++;
            if (a_oe !== 1'b1 || a_mem_ack !== (c == 4)) begin
                n_err++; $display("FAIL rdwr_c%0d got oe%b ack%b want oe1 ack%b", c, a_oe, a_mem_ack, c == 4);
            end
        end
        n_vec++;
        if (mem_a[16'h2000] !== 16'hBEEF || a_mem_rdata !== 16'h0F0F) begin
            n_err++; $display("FAIL rdwr_result got mem %h rdata %h want beef 0f0f",
                              mem_a[16'h2000], a_mem_rdata);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_pulse();
        mem_addr = 16'h1000; mem_wdata = 16'h5555; mem_write = 1'b1;
        tick();
        tick();
        n_vec++;
        if (a_we !== 1'b0) begin
            n_err++; $display("FAIL pulse_reached got we%b want 0", a_we);
        end
        RST = 1'b1;
        tick();
        n_vec++;
        if ({a_oe, a_we, a_en, a_mem_ack} !== 4'b1110 || a_data !== 16'h0000 || a_addr !== 18'h0) begin
            n_err++; $display("FAIL rst_pulse got oe%b we%b en%b ack%b bus %h addr %h",
                              a_oe, a_we, a_en, a_mem_ack, a_data, a_addr);
        end
        RST = 1'b0; mem_write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (a_mem_ack !== 1'b0) begin
                n_err++; $display("FAIL rst_no_ack got %b want 0", a_mem_ack);
            end
        end
        n_vec++;
        if (mem_a[16'h1000] !== 16'hAAAA) begin
            n_err++; $display("FAIL rst_mem got %h want aaaa", mem_a[16'h1000]);
        end
    endtask

    task automatic test_param_sweep();
        sel2 = 1'b1;
        if_addr = 16'h0040; if_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_vec++;
            if (b_oe !== (c == 4) || b_if_ack !== (c == 4) || b_stall !== (c != 4)) begin
                n_err++; $display("FAIL sweep_rd_c%0d got oe%b ack%b st%b", c, b_oe, b_if_ack, b_stall);
            end
        end
        n_vec++;
        if (b_if_rdata !== 16'h6801 || b_addr !== 18'h00040) begin
            n_err++; $display("FAIL sweep_rdata got %h @%h want 6801 @00040", b_if_rdata, b_addr);
        end
        if_req = 1'b0;
        tick();
        mem_addr = 16'h3000; mem_wdata = 16'hC0DE; mem_write = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_vec++;
            if (b_we !== !(c == 2 || c == 3) || b_mem_ack !== (c == 5)) begin
                n_err++; $display("FAIL sweep_wr_c%0d got we%b ack%b want we%b ack%b",
                                  c, b_we, b_mem_ack, !(c == 2 || c == 3), c == 5);
            end
        end
        mem_write = 1'b0;
        n_vec++;
        if (mem_b[16'h3000] !== 16'hC0DE || b_mem_rdata !== 16'h0000) begin
            n_err++; $display("FAIL sweep_wr_result got mem %h rdata %h want c0de 0000",
                              mem_b[16'h3000], b_mem_rdata);
        end
        tick();
        sel2 = 1'b0;
    endtask

    initial begin
        mem_a[16'h0040] = 16'h6801;
        mem_a[16'hFFFF] = 16'h0F0F;
        mem_a[16'h1000] = 16'hAAAA;
        mem_b[16'h0040] = 16'h6801;
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_drop_top_addr();
        test_read_and_write();
        test_reset_in_pulse();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
